// File: rtl/sequencer_fsm_v2_if.sv
// Memory-port bundle between the sequencer and the instruction/data memory.
//   msel      : address source select (0 = PC, 1 = C), driven by the sequencer
//   mread     : read request strobe, driven by the sequencer
//   mwrite    : write request strobe, driven by the sequencer
//   mem_ready : memory has completed the current access, driven by the memory
// master modport = sequencer side, slave modport = memory side.
interface sequencer_fsm_v2_if;
  logic msel;
  logic mread;
  logic mwrite;
  logic mem_ready;

  modport master (output msel, mread, mwrite, input mem_ready);
  modport slave  (input msel, mread, mwrite, output mem_ready);
endinterface

// File: rtl/sequencer_fsm_v2.sv
// sequencer_fsm_v2 -- multicycle instruction controller for the simple RISC
// core. Sequences fetch, decode, register read, ALU execute, write-back and
// memory accesses, with a ready/valid memory handshake, a bounded wait
// (MEM_TIMEOUT cycles, 0 = unbounded) and a HALT instruction.
//
// Optional feature: define SEQ_BRANCH_EN to decode B<cond>, BL and BX.
// Without it those opcodes end in the error state.
//
// Ports:
//   clk, reset         : clock (rising edge), asynchronous active-low reset
//   opcode, op, cond   : instruction register fields IR[15:13], [12:11], [10:8]
//   N, V, Z            : status flags
//   mem                : memory port (msel/mread/mwrite out, mem_ready in)
//   nsel, vsel         : register select, write-back source select
//   loada/b/c, loads   : datapath latch enables
//   write              : register file write enable
//   asel, bsel         : ALU operand selects
//   loadpc, pcsel      : PC load enable and next-PC select
//   loadir             : instruction register load enable
//   halted, err        : core stopped on HALT / memory timeout or illegal op
module sequencer_fsm_v2 #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                opcode,
  input  logic [1:0]                op,
  input  logic [2:0]                cond,
  input  logic                      N,
  input  logic                      V,
  input  logic                      Z,
  sequencer_fsm_v2_if.master        mem,
  output logic [1:0]                nsel,
  output logic [1:0]                vsel,
  output logic                      loada,
  output logic                      loadb,
  output logic                      loadc,
  output logic                      loads,
  output logic                      write,
  output logic                      asel,
  output logic                      bsel,
  output logic                      loadpc,
  output logic [1:0]                pcsel,
  output logic                      loadir,
  output logic                      halted,
  output logic                      err
);

  typedef enum logic [4:0] {
    S_RST, S_IF, S_UPD, S_DEC, S_WIMM, S_RDM, S_RDN, S_EXE, S_WB,
    S_MADR, S_MWR1, S_MRD, S_MWR, S_HLT, S_ERR,
    S_BRC, S_BLK, S_BXR, S_BXP
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_t              state, state_n;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_clr, wait_inc;
  logic                timeout;

  // Instruction classes, decoded straight from the IR fields, which stay
  // stable from the UPD cycle until the next fetch.
  logic is_alu, is_mov_imm, is_mov_reg, is_ldr, is_str, is_halt;
  logic alu_cmp, alu_mvn;
  logic is_b, is_bl, is_bx;

  assign is_alu     = (opcode == 3'b101);
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_ldr     = (opcode == 3'b011) && (op == 2'b00);
  assign is_str     = (opcode == 3'b100) && (op == 2'b00);
  assign is_halt    = (opcode == 3'b111);
  assign alu_cmp    = is_alu && (op == 2'b01);
  assign alu_mvn    = is_alu && (op == 2'b11);

`ifdef SEQ_BRANCH_EN
  assign is_b  = (opcode == 3'b001) && (op == 2'b00);
  assign is_bl = (opcode == 3'b010) && (op == 2'b11);
  assign is_bx = (opcode == 3'b010) && (op == 2'b00);

  // Branch condition evaluation; cond_bad flags the reserved encodings.
  logic cond_true, cond_bad;
  always_comb begin
    cond_true = 1'b0;
    cond_bad  = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = Z;
      3'b010:  cond_true = ~Z;
      3'b011:  cond_true = (N != V);
      3'b100:  cond_true = (N != V) | Z;
      default: cond_bad  = 1'b1;
    endcase
  end
`else
  assign is_b  = 1'b0;
  assign is_bl = 1'b0;
  assign is_bx = 1'b0;
  // Branch inputs have no consumer in this build.
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{cond, N, V, Z};
`endif

  // A zero MEM_TIMEOUT disables the bound entirely.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (wait_clr)
        wait_cnt <= '0;
      else if (wait_inc && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // NOTE: every output and next-state term gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_n    = state;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    nsel       = 2'b00;
    vsel       = 2'b00;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    write      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    loadpc     = 1'b0;
    pcsel      = 2'b00;
    loadir     = 1'b0;
    mem.msel   = 1'b0;
    mem.mread  = 1'b0;
    mem.mwrite = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;

    case (state)
      S_RST: begin
        loadpc  = 1'b1;
        pcsel   = 2'b11;
        state_n = S_IF;
      end

      S_IF: begin
        mem.mread = 1'b1;
        if (mem.mem_ready) begin
          loadir   = 1'b1;
          wait_clr = 1'b1;
          state_n  = S_UPD;
        end else if (timeout) begin
          wait_clr = 1'b1;
          state_n  = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_UPD: begin
        loadpc  = 1'b1;
        state_n = S_DEC;
      end

      S_DEC: begin
        if (is_mov_imm)                 state_n = S_WIMM;
        else if (is_mov_reg || is_alu)  state_n = S_RDM;
        else if (is_ldr || is_str)      state_n = S_RDN;
        else if (is_halt)               state_n = S_HLT;
        else if (is_b)                  state_n = S_BRC;
        else if (is_bl)                 state_n = S_BLK;
        else if (is_bx)                 state_n = S_BXR;
        else                            state_n = S_ERR;
      end

      S_WIMM: begin
        vsel    = 2'b01;
        write   = 1'b1;
        state_n = S_IF;
      end

      S_RDM: begin
        nsel    = 2'b10;
        loadb   = 1'b1;
        // MOV reg and MVN are single-operand: skip reading Rn.
        state_n = (is_mov_reg || alu_mvn) ? S_EXE : S_RDN;
      end

      S_RDN: begin
        loada   = 1'b1;
        state_n = S_EXE;
      end

      S_EXE: begin
        if (alu_cmp) loads = 1'b1;
        else         loadc = 1'b1;
        if (is_mov_reg || alu_mvn || is_bx) asel = 1'b1;
        else if (is_ldr || is_str)          bsel = 1'b1;
        if (alu_cmp)                  state_n = S_IF;
        else if (is_ldr || is_str)    state_n = S_MADR;
        else if (is_bx)               state_n = S_BXP;
        else                          state_n = S_WB;
      end

      S_WB: begin
        nsel    = 2'b01;
        vsel    = 2'b11;
        write   = 1'b1;
        state_n = S_IF;
      end

      S_MADR: begin
        if (is_str) begin
          // Store data (Rd) goes through B so it can pass to the write bus.
          nsel    = 2'b01;
          loadb   = 1'b1;
          state_n = S_MWR1;
        end else begin
          state_n = S_MRD;
        end
      end

      S_MWR1: begin
        asel    = 1'b1;
        state_n = S_MWR;
      end

      S_MRD: begin
        mem.msel  = 1'b1;
        mem.mread = 1'b1;
        if (mem.mem_ready) begin
          nsel     = 2'b01;
          write    = 1'b1;
          wait_clr = 1'b1;
          state_n  = S_IF;
        end else if (timeout) begin
          wait_clr = 1'b1;
          state_n  = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_MWR: begin
        mem.msel   = 1'b1;
        mem.mwrite = 1'b1;
        if (mem.mem_ready) begin
          wait_clr = 1'b1;
          state_n  = S_IF;
        end else if (timeout) begin
          wait_clr = 1'b1;
          state_n  = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_HLT: halted = 1'b1;

      S_ERR: err = 1'b1;

`ifdef SEQ_BRANCH_EN
      S_BRC: begin
        // BL reaches here with its link already written and always branches.
        if (!is_bl && cond_bad) begin
          state_n = S_ERR;
        end else begin
          if (is_bl || cond_true) begin
            loadpc = 1'b1;
            pcsel  = 2'b01;
          end
          state_n = S_IF;
        end
      end

      S_BLK: begin
        nsel    = 2'b11;
        vsel    = 2'b10;
        write   = 1'b1;
        state_n = S_BRC;
      end

      S_BXR: begin
        nsel    = 2'b01;
        loadb   = 1'b1;
        state_n = S_EXE;
      end

      S_BXP: begin
        loadpc  = 1'b1;
        pcsel   = 2'b10;
        state_n = S_IF;
      end
`endif

      default: state_n = S_ERR;
    endcase

    // Outputs are forced low for as long as reset is held, so an access in
    // flight (e.g. a pending mwrite) is withdrawn without waiting for a clock.
    if (!reset) begin
      nsel       = 2'b00;
      vsel       = 2'b00;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      write      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      loadpc     = 1'b0;
      pcsel      = 2'b00;
      loadir     = 1'b0;
      mem.msel   = 1'b0;
      mem.mread  = 1'b0;
      mem.mwrite = 1'b0;
      halted     = 1'b0;
      err        = 1'b0;
    end
  end

endmodule

// File: tb/tb_sequencer_fsm_v2.sv
// Directed testbench for sequencer_fsm_v2: walks MOV imm, ADD, CMP, LDR with
// memory wait states, STR aborted by reset, fetch timeout, HALT and a
// conditional branch, comparing every control output against hand-derived
// vectors each cycle.
module tb_sequencer_fsm_v2;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, write, asel, bsel, loadpc;
    logic [1:0] pcsel;
    logic       loadir, msel, mread, mwrite, halted, err;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [2:0] cond = 3'b000;
  logic       N = 1'b0, V = 1'b0, Z = 1'b0;
  logic [1:0] nsel, vsel, pcsel;
  logic       loada, loadb, loadc, loads, write, asel, bsel, loadpc, loadir;
  logic       halted, err;

  int n_checks = 0;
  int n_errors = 0;

  sequencer_fsm_v2_if mem ();

  sequencer_fsm_v2 #(.MEM_TIMEOUT(15), .WAIT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .op     (op),
    .cond   (cond),
    .N      (N),
    .V      (V),
    .Z      (Z),
    .mem    (mem.master),
    .nsel   (nsel),
    .vsel   (vsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .write  (write),
    .asel   (asel),
    .bsel   (bsel),
    .loadpc (loadpc),
    .pcsel  (pcsel),
    .loadir (loadir),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  outs_t obs;
  assign obs = {nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
                loadpc, pcsel, loadir, mem.msel, mem.mread, mem.mwrite,
                halted, err};

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input outs_t e);
    #1;
    check(tag, 32'(obs), 32'(e));
  endtask

  // Runs IF (zero wait), UPD and DEC from the IF state; ends in the first
  // execute state.
  task automatic fetch(input logic [2:0] oc, input logic [1:0] o2,
                       input string tag);
    outs_t e;
    opcode = oc;
    op = o2;
    mem.mem_ready = 1'b1;
    e = '0; e.mread = 1'b1; e.loadir = 1'b1;
    expect_out({tag, "_if"}, e);
    cyc(); e = '0; e.loadpc = 1'b1; e.pcsel = 2'b00;
    expect_out({tag, "_upd"}, e);
    cyc(); e = '0;
    expect_out({tag, "_dec"}, e);
    cyc();
  endtask

  // Pulses reset for one cycle, checks the reset and RST outputs, ends in IF.
  task automatic do_reset(input string tag);
    outs_t e;
    reset = 1'b0;
    e = '0;
    expect_out({tag, "_rst_low"}, e);
    cyc();
    reset = 1'b1;
    e = '0; e.loadpc = 1'b1; e.pcsel = 2'b11;
    expect_out({tag, "_rst_state"}, e);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t e;
    mem.mem_ready = 1'b1;

    // Reset held for three cycles: every output low.
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = '0;
      expect_out("reset_hold", e);
    end
    reset = 1'b1;
    e = '0; e.loadpc = 1'b1; e.pcsel = 2'b11;
    expect_out("rst_state", e);
    cyc();

    // MOV R1,#5
    fetch(3'b110, 2'b10, "movi");
    e = '0; e.vsel = 2'b01; e.write = 1'b1;
    expect_out("movi_wimm", e);
    cyc();

    // ADD: RDM, RDN, EXE, WB
    fetch(3'b101, 2'b00, "add");
    e = '0; e.nsel = 2'b10; e.loadb = 1'b1; expect_out("add_rdm", e);
    cyc(); e = '0; e.loada = 1'b1;          expect_out("add_rdn", e);
    cyc(); e = '0; e.loadc = 1'b1;          expect_out("add_exe", e);
    cyc(); e = '0; e.nsel = 2'b01; e.vsel = 2'b11; e.write = 1'b1;
    expect_out("add_wb", e);
    cyc();

    // CMP: status latch instead of C, no write-back
    fetch(3'b101, 2'b01, "cmp");
    e = '0; e.nsel = 2'b10; e.loadb = 1'b1; expect_out("cmp_rdm", e);
    cyc(); e = '0; e.loada = 1'b1;          expect_out("cmp_rdn", e);
    cyc(); e = '0; e.loads = 1'b1;          expect_out("cmp_exe", e);
    cyc();

    // LDR with three wait cycles in MRD
    fetch(3'b011, 2'b00, "ldr");
    e = '0; e.loada = 1'b1;                 expect_out("ldr_rdn", e);
    cyc(); e = '0; e.loadc = 1'b1; e.bsel = 1'b1; expect_out("ldr_exe", e);
    cyc(); e = '0;                          expect_out("ldr_madr", e);
    cyc();
    mem.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.msel = 1'b1; e.mread = 1'b1;
      expect_out("ldr_mrd_wait", e);
      cyc();
    end
    mem.mem_ready = 1'b1;
    e = '0; e.nsel = 2'b01; e.vsel = 2'b00; e.write = 1'b1;
    e.msel = 1'b1; e.mread = 1'b1;
    expect_out("ldr_mrd_ready", e);
    cyc();

    // STR, aborted by reset while the write is pending
    fetch(3'b100, 2'b00, "str");
    e = '0; e.loada = 1'b1;                 expect_out("str_rdn", e);
    cyc(); e = '0; e.loadc = 1'b1; e.bsel = 1'b1; expect_out("str_exe", e);
    cyc(); e = '0; e.nsel = 2'b01; e.loadb = 1'b1; expect_out("str_madr", e);
    cyc(); e = '0; e.asel = 1'b1;           expect_out("str_mwr1", e);
    cyc();
    mem.mem_ready = 1'b0;
    e = '0; e.msel = 1'b1; e.mwrite = 1'b1;
    expect_out("str_mwr", e);
    do_reset("str_abort");

    // Fetch timeout: sixteen IF cycles (count 0..15), then ERR
    mem.mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = '0; e.mread = 1'b1;
      expect_out("tmo_if_wait", e);
      cyc();
    end
    e = '0; e.err = 1'b1;
    expect_out("tmo_err", e);
    cyc();
    expect_out("tmo_err_hold", e);
    do_reset("tmo_clear");

    // HALT is absorbing
    fetch(3'b111, 2'b00, "halt");
    for (int i = 0; i < 20; i++) begin
      e = '0; e.halted = 1'b1;
      expect_out("halt_hold", e);
      cyc();
    end
    do_reset("halt_clear");

    // B EQ (cond 001)
    cond = 3'b001;
    Z = 1'b0;
    fetch(3'b001, 2'b00, "beq_nt");
`ifdef SEQ_BRANCH_EN
    e = '0;
    expect_out("beq_not_taken", e);
    cyc();
    Z = 1'b1;
    fetch(3'b001, 2'b00, "beq_t");
    e = '0; e.loadpc = 1'b1; e.pcsel = 2'b01;
    expect_out("beq_taken", e);
    cyc();
    e = '0; e.mread = 1'b1; e.loadir = 1'b1;
    expect_out("beq_back_to_if", e);
`else
    e = '0; e.err = 1'b1;
    expect_out("beq_illegal", e);
    cyc();
    expect_out("beq_illegal_hold", e);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequencer_fsm_v2.md
Name: sequencer_fsm_v2

Overview:
- Multicycle control FSM for the simple RISC core; second generation of the instruction controller.
- Drives register file, A/B/C/status latches, PC, instruction register and memory port.
- Over the previous controller, adds:
  - a memory ready/valid handshake with variable latency and a timeout;
  - a HALT instruction;
  - optional branch support.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready; 0 disables the timeout.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  3  IR[15:13].
- op  in  2  IR[12:11].
- cond  in  3  IR[10:8], branch condition.
- N, V, Z  in  1 each  status flags from the status register.
- mem_ready  in  1  memory has completed the current access.
- nsel  out  2  register select: 00 Rn, 01 Rd, 10 Rm, 11 R7.
- vsel  out  2  write-back source: 00 mdata, 01 sximm8, 10 PC, 11 C.
- loada, loadb, loadc, loads, write  out  1 each  datapath latch and write enables.
- asel, bsel  out  1 each  ALU operand selects.
- loadpc  out  1  PC load enable.
- pcsel  out  2  next PC: 00 PC+1, 01 PC+sximm8, 10 C, 11 zero.
- loadir  out  1  IR load enable.
- msel  out  1  memory address source: 0 PC, 1 C.
- mread, mwrite  out  1 each  memory request strobes.
- halted  out  1  core stopped on HALT.
- err  out  1  memory timeout or illegal opcode.

Behaviour:
- Reset (async, active-low):
  - State goes to RST.
  - All outputs are 0 and the wait counter clears.
  - Reset asserted mid-instruction aborts immediately; a pending mwrite drops the same cycle.
- Outputs are Moore, decoded from the state only, except loadir and the exits of the wait states, which also depend on mem_ready.
- States and transitions:
  - RST: loadpc=1, pcsel=11. Next: IF.
  - IF: msel=0, mread=1.
    - If mem_ready: loadir=1 in the same cycle, next UPD.
    - Otherwise stay in IF and increment the wait counter.
  - UPD: loadpc=1, pcsel=00. Next: DEC.
  - DEC: no outputs asserted. Dispatch by {opcode,op}:
    - 110/10 MOV imm: WIMM.
    - 110/00 MOV reg: RDM.
    - 101/xx ALU: RDM.
    - 011/00 LDR: RDN.
    - 100/00 STR: RDN.
    - 111/xx HALT: HLT.
    - Branch opcodes: see Optional Feature.
    - Anything else: ERR.
  - WIMM: nsel=00, vsel=01, write=1. Next: IF.
  - RDM: nsel=10, loadb=1.
    - Next is RDN for ADD, CMP and AND.
    - Next is EXE for MOV reg and MVN.
  - RDN: nsel=00, loada=1.
    - Next is EXE for ALU ops; the memory ops use the same EXE state.
  - EXE:
    - loadc=1, except CMP, which asserts loads=1 and loadc=0.
    - MOV reg and MVN: asel=1, bsel=0.
    - LDR and STR: asel=0, bsel=1.
    - All others: asel=0, bsel=0.
    - Next: IF for CMP, WB for the other ALU ops, MADR for LDR and STR.
  - WB: nsel=01, vsel=11, write=1. Next: IF.
  - MADR:
    - LDR: next MRD.
    - STR: nsel=01, loadb=1, next MWR1.
  - MWR1: asel=1, bsel=0, loadc=0. B passes to the write-data bus. Next: MWR.
  - MRD: msel=1, mread=1.
    - On mem_ready: nsel=01, vsel=00, write=1, next IF.
    - Otherwise stay and count.
  - MWR: msel=1, mwrite=1. On mem_ready next IF; otherwise stay and count.
  - HLT: halted=1. Absorbing until reset.
  - ERR: err=1. Absorbing until reset.
- Wait counter:
  - Cleared on every wait-state exit.
  - When the count equals MEM_TIMEOUT (nonzero) with mem_ready low, the next state is ERR and the strobes drop.
  - mem_ready arriving on the timeout cycle wins over the timeout.
- Fetch latency with zero-wait memory: IF, UPD, DEC = 3 cycles.
- Total cycles with zero-wait memory: MOV imm 4; ADD 7; CMP 6; LDR 7; STR 8.

Optional Feature:
- Macro: SEQ_BRANCH_EN.
- When defined, DEC additionally dispatches:
  - 001/00 B<cond> to BRC;
  - 010/11 BL to BLK;
  - 010/00 BX to BXR.
- BRC: taken evaluates cond as 000 always, 001 Z, 010 !Z, 011 N!=V, 100 (N!=V)|Z; 101–111 give ERR.
  - If taken: loadpc=1, pcsel=01.
  - Next: IF.
- BLK: nsel=11, vsel=10, write=1, then BRC with forced taken.
- BXR: nsel=01, loadb=1, then EXE with asel=1, bsel=0, loadc=1, then a cycle with loadpc=1, pcsel=10. Next: IF.
- Without the macro, these opcodes go to ERR.

Test Plan:
- Hold reset low 3 cycles, release, mem_ready=1 with IR=MOV R1,#5 (110 10): loadpc with pcsel=11, then IF, UPD, DEC, then WIMM with write=1, vsel=01, nsel=00.
- ADD (101 00), mem_ready=1: loadb at cycle 4, loada at 5, loadc at 6, write with vsel=11 at 7; loads never asserts.
- LDR with mem_ready low 3 cycles in MRD: mread and msel held high 4 cycles; write only on the ready cycle.
- MEM_TIMEOUT=15, mem_ready stuck low in IF: err=1 after 15 wait cycles, mread=0 thereafter; reset clears err.
- HALT (111): halted=1 and stays across 20 cycles; no loadpc.
- With SEQ_BRANCH_EN: B EQ with Z=0 gives no loadpc in BRC; with Z=1 gives loadpc=1, pcsel=01. Without the macro, the same opcode gives err=1.
